// File: rtl/dmem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake with a fixed
// access latency, error flagging for misaligned or out-of-range byte addresses, and a completion counter.
module dmem_responder #(
  parameter int n       = 16,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err,
  input  logic         resp_ready,
  output logic         stall,
  output logic [n-1:0] txn_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, state_next;
  logic [2:0]     cnt;
  logic           we_q;
  logic [n-1:0]   addr_q;
  logic [n-1:0]   wdata_q;
  logic [n-1:0]   rdata_q;
  logic           err_q;
  logic [n-1:0]   mem [2**AW];

  logic           accept;
  logic           commit;
  logic           done;
  logic           addr_bad;
  logic [AW-1:0]  word_idx;

  assign accept   = (state == IDLE) && req_valid;
  assign commit   = (state == WAIT) && (cnt == 3'd0);
  assign done     = (state == RESP) && resp_ready;
  assign word_idx = addr_q[AW:1];
  // Odd byte address, or any address bit above the storage range.
  assign addr_bad = addr_q[0] | (|(addr_q >> (AW + 1)));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)  state_next = WAIT;
      WAIT:    if (cnt == 3'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = (state == RESP) ? rdata_q : '0;
    resp_err   = (state == RESP) && err_q;
    stall      = accept || (state == WAIT) || ((state == RESP) && !resp_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 3'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 3'(LATENCY - 1);
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (commit) begin
        err_q   <= addr_bad;
        rdata_q <= (addr_bad || we_q) ? '0 : mem[word_idx];
      end
      if (done) txn_count <= txn_count + n'(1);
    end
  end

  // NOTE: the storage array has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (commit && we_q && !addr_bad) mem[word_idx] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: default build plus two small builds
// (n=8, AW=4) at latency 7 and 1 that exercise latency extremes and txn_count wrap.
module tb_dmem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic        err;
    logic [15:0] data;
    bit          known;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_ready;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_ready, stall;
  logic [15:0] resp_rdata, txn_count;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [15:0] model [int];
  logic [15:0] exp_txn = '0;

  always #5 clk = ~clk;

  dmem_responder #(.n(16), .AW(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_ready(resp_ready), .stall(stall), .txn_count(txn_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every completed response handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL resp_unexpected: response with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", resp_err, e.err);
          if (e.known) check("resp_rdata", resp_rdata, e.data);
          exp_txn = exp_txn + 16'd1;
          @(posedge clk);
          #1;
          check("txn_count", txn_count, exp_txn);
        end
      end
    end
  end

  // One complete transaction; hold = cycles of backpressure once the response is up.
  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int hold);
    exp_t        e;
    int          edges;
    logic [15:0] held_data;
    logic        held_err;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    #1;
    check("req_ready_idle", req_ready, 1);
    check("stall_idle_req", stall, 1);
    e.err   = addr[0] || (addr >= 16'h0200);
    e.data  = '0;
    e.known = 1'b1;
    if (!e.err) begin
      if (we) begin
        model[int'(addr >> 1)] = wdata;
        e.known = 1'b0;
      end else if (model.exists(int'(addr >> 1))) begin
        e.data = model[int'(addr >> 1)];
      end else begin
        e.known = 1'b0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    // Garbage on the request bus must not disturb the latched transaction.
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    edges = 0;
    while (!resp_valid && edges < 20) begin
      check("stall_wait", stall, 1);
      check("req_ready_busy", req_ready, 0);
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", edges, LAT);
    held_data = resp_rdata;
    held_err  = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, held_data);
      check("hold_err", resp_err, held_err);
      check("hold_stall", stall, 1);
      check("hold_txn", txn_count, exp_txn);
    end
    resp_ready = 1'b1;
    #1;
    check("stall_resp_ready", stall, 0);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    #1;
    check("idle_resp_valid", resp_valid, 0);
    check("idle_resp_rdata", resp_rdata, 0);
    check("idle_resp_err", resp_err, 0);
    check("idle_req_ready", req_ready, 1);
  endtask

  // Small builds: latency extremes and txn_count wrap after 256 completions.
  for (genvar g = 0; g < 2; g++) begin : g_small
    localparam int L = (g == 0) ? 7 : 1;
    logic       s_reset, s_req_valid, s_req_we, s_req_ready;
    logic       s_resp_valid, s_resp_err, s_resp_ready, s_stall;
    logic [7:0] s_req_addr, s_req_wdata, s_resp_rdata, s_txn;
    logic       done = 1'b0;

    dmem_responder #(.n(8), .AW(4), .LATENCY(L)) u_small (
      .clk(clk), .reset(s_reset),
      .req_valid(s_req_valid), .req_we(s_req_we), .req_addr(s_req_addr),
      .req_wdata(s_req_wdata), .req_ready(s_req_ready),
      .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
      .resp_ready(s_resp_ready), .stall(s_stall), .txn_count(s_txn)
    );

    initial begin : run
      int edges;
      s_reset      = 1'b1;
      s_req_valid  = 1'b0;
      s_req_we     = 1'b0;
      s_req_addr   = '0;
      s_req_wdata  = '0;
      s_resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      s_reset = 1'b0;
      #1;
      check("small_reset_txn", s_txn, 0);
      check("small_reset_ready", s_req_ready, 1);
      for (int t = 0; t < 256; t++) begin
        s_req_valid  = 1'b1;
        s_req_we     = (t == 0);
        s_req_addr   = 8'h06;
        s_req_wdata  = 8'hA5;
        s_resp_ready = 1'b0;
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        edges = 0;
        while (!s_resp_valid && edges < 20) begin
          @(posedge clk);
          #1;
          edges++;
        end
        check((L == 7) ? "latency7" : "latency1", edges, L);
        check("small_err", s_resp_err, 0);
        if (t > 0) check("small_rdata", s_resp_rdata, 8'hA5);
        s_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        s_resp_ready = 1'b0;
        if (t == 254) check("small_txn_ff", s_txn, 8'hFF);
        if (t == 255) check("small_txn_wrap", s_txn, 8'h00);
      end
      done = 1'b1;
    end
  end

  initial begin : stimulus
    int          w;
    int          r;
    logic        we;
    logic [15:0] addr;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    #2;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_txn", txn_count, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_stall", stall, 0);
    check("post_rst_rdata", resp_rdata, 0);
    check("post_rst_err", resp_err, 0);

    // Store then load, misaligned store, out-of-range load, backpressure.
    do_txn(1'b1, 16'h0010, 16'hABCD, 0);
    do_txn(1'b0, 16'h0010, 16'h0000, 0);
    check("txn_after_pair", txn_count, 2);
    do_txn(1'b1, 16'h0011, 16'h1234, 0);
    do_txn(1'b0, 16'h0010, 16'h0000, 1);
    do_txn(1'b0, 16'h0200, 16'h0000, 2);
    do_txn(1'b0, 16'h0010, 16'h0000, 5);

    // Reset during WAIT of a store drops it.
    do_txn(1'b1, 16'h0020, 16'h1111, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    check("mid_stall_wait", stall, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_rdata", resp_rdata, 0);
    check("mid_rst_err", resp_err, 0);
    check("mid_rst_txn", txn_count, 0);
    check("mid_rst_stall", stall, 0);
    exp_txn = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1);
    do_txn(1'b0, 16'h0020, 16'h0000, 0);
    do_txn(1'b0, 16'h0010, 16'h0000, 0);

    // Randomised traffic over a small address window with occasional bad addresses.
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      addr = 16'($urandom_range(0, 15) * 2);
      if (r == 7) addr = addr | 16'h0001;
      else if (r >= 8) addr = 16'($urandom);
      do_txn(we, addr, 16'($urandom), $urandom_range(0, 3));
    end

    w = 0;
    while (!(g_small[0].done && g_small[1].done) && w < 20000) begin
      @(posedge clk);
      w++;
    end
    check("small_builds_done", {30'd0, g_small[1].done, g_small[0].done}, 3);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
